// File: rtl/pgen_pkg.sv
// Shared definitions for the payload generator: payload source encodings,
// FSM states and the Galois LFSR polynomial used for pseudo-random payload.
package pgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } pgen_state_t;

    localparam logic [1:0]  MODE_LFSR  = 2'd0;
    localparam logic [1:0]  MODE_INCR  = 2'd1;
    localparam logic [1:0]  MODE_FIXED = 2'd2;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET = 32'hFFFF_FFFF;

    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        if (state[0]) begin
            lfsr_next = {1'b0, state[31:1]} ^ LFSR_TAPS;
        end else begin
            lfsr_next = {1'b0, state[31:1]};
        end
    endfunction

    // Reserved encoding 3 behaves as LFSR mode.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        case (mode)
            MODE_INCR:  norm_mode = MODE_INCR;
            MODE_FIXED: norm_mode = MODE_FIXED;
            default:    norm_mode = MODE_LFSR;
        endcase
    endfunction

    // Byte sel of a 32-bit word, sel 0 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        case (sel)
            2'd0:    word_byte = word[31:24];
            2'd1:    word_byte = word[23:16];
            2'd2:    word_byte = word[15:8];
            default: word_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/payload_lfsr32.sv
// 32-bit Galois LFSR holding the pseudo-random payload word; loadable seed,
// advances only on request so the state survives stalls and packet gaps.
module payload_lfsr32
    import pgen_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_advance,
    output logic [31:0] o_state
);

    logic [31:0] state_r;

    // LFSR state register: seed load has priority over advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= LFSR_RESET;
        end else if (i_load) begin
            state_r <= i_seed;
        end else if (i_advance) begin
            state_r <= lfsr_next(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign o_state = state_r;

endmodule

// File: rtl/payload_gen.sv
// Test-traffic payload generator: sequence-number header followed by LFSR,
// incrementing or fixed payload, emitted as an MSB-first valid/ready byte-lane stream.
module payload_gen
    import pgen_pkg::*;
#(
    parameter int          DATA_BYTES = 1,
    parameter int          LEN_W      = 16,
    parameter logic [31:0] SEQ_INIT   = 32'h0123_4567
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [LEN_W-1:0]        i_len,
    input  logic [1:0]              i_mode,
    input  logic [7:0]              i_pattern,
    input  logic                    i_seed_load,
    input  logic [31:0]             i_seed_data,
    output logic [8*DATA_BYTES-1:0] o_data,
    output logic [DATA_BYTES-1:0]   o_keep,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last,
    output logic                    o_busy,
    output logic [31:0]             o_seq
);

    localparam int                DW      = 8 * DATA_BYTES;
    localparam int                PW      = LEN_W + 1;
    localparam logic [PW-1:0]     STEP    = PW'(DATA_BYTES);
    localparam logic [PW-1:0]     HDR_LEN = PW'(4);
    localparam logic [LEN_W-1:0]  MIN_LEN = LEN_W'(4);

    if (!(DATA_BYTES == 1 || DATA_BYTES == 2 || DATA_BYTES == 4)) begin : g_bad_data_bytes
        $error("payload_gen: DATA_BYTES must be 1, 2 or 4");
    end

    pgen_state_t       state_r, state_s;
    logic [PW-1:0]     len_r, len_s;
    logic [1:0]        mode_r, mode_s;
    logic [7:0]        pattern_r, pattern_s;
    logic [PW-1:0]     pos_r, pos_s;
    logic [31:0]       seq_r, seq_s;
    logic [DW-1:0]     data_r, data_s;
    logic [DATA_BYTES-1:0] keep_r, keep_s;
    logic              valid_r, valid_s;
    logic              last_r, last_s;
    logic              busy_r, busy_s;

    logic              accept_s;
    logic [PW-1:0]     pos_next_s;
    logic              lfsr_load_s;
    logic              lfsr_adv_s;
    logic [31:0]       lfsr_state_s;

    logic [PW-1:0]     src_pos_s;
    logic [PW-1:0]     src_len_s;
    logic [1:0]        src_mode_s;
    logic [7:0]        src_pat_s;
    logic [31:0]       src_lfsr_s;
    logic [DW-1:0]     bld_data_s;
    logic [DATA_BYTES-1:0] bld_keep_s;
    logic              bld_last_s;

    // Byte at packet offset idx: header bytes come from seq, payload from the selected source.
    function automatic logic [7:0] lane_byte(
        input logic [PW-1:0] idx,
        input logic [1:0]    mode,
        input logic [7:0]    pat,
        input logic [31:0]   seq,
        input logic [31:0]   lfsr
    );
        if (idx < HDR_LEN) begin
            lane_byte = word_byte(seq, idx[1:0]);
        end else begin
            case (mode)
                MODE_INCR:  lane_byte = idx[7:0] - 8'd4;
                MODE_FIXED: lane_byte = pat;
                default:    lane_byte = word_byte(lfsr, idx[1:0]);
            endcase
        end
    endfunction

    payload_lfsr32 u_lfsr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (lfsr_load_s),
        .i_seed    (i_seed_data),
        .i_advance (lfsr_adv_s),
        .o_state   (lfsr_state_s)
    );

    assign accept_s   = valid_r & i_ready;
    assign pos_next_s = pos_r + STEP;
    // Advance after a word's final byte leaves, or after a truncated final word.
    assign lfsr_adv_s = accept_s && (state_r == ST_PAYLOAD) && (mode_r == MODE_LFSR)
                        && ((pos_next_s[1:0] == 2'b00) || last_r);

    // Selects what the next registered beat is built from: fresh inputs at start, latched context otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            src_pos_s  = '0;
            src_len_s  = (i_len < MIN_LEN) ? HDR_LEN : {1'b0, i_len};
            src_mode_s = norm_mode(i_mode);
            src_pat_s  = i_pattern;
            src_lfsr_s = lfsr_state_s;
        end else begin
            src_pos_s  = pos_next_s;
            src_len_s  = len_r;
            src_mode_s = mode_r;
            src_pat_s  = pattern_r;
            src_lfsr_s = lfsr_adv_s ? lfsr_next(lfsr_state_s) : lfsr_state_s;
        end
    end

    // Beat builder: fills lanes MSB-first, zeroing and unkeeping lanes past the packet end.
    always_comb begin
        bld_data_s = '0;
        bld_keep_s = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if ((src_pos_s + PW'(k)) < src_len_s) begin
                bld_keep_s[DATA_BYTES-1-k] = 1'b1;
                bld_data_s[DW-1-8*k -: 8]  = lane_byte(src_pos_s + PW'(k), src_mode_s,
                                                       src_pat_s, seq_r, src_lfsr_s);
            end else begin
                bld_keep_s[DATA_BYTES-1-k] = 1'b0;
            end
        end
        bld_last_s = (src_pos_s + STEP) >= src_len_s;
    end

    // Next-state and next-output logic for the packet FSM.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        mode_s      = mode_r;
        pattern_s   = pattern_r;
        pos_s       = pos_r;
        seq_s       = seq_r;
        data_s      = data_r;
        keep_s      = keep_r;
        valid_s     = valid_r;
        last_s      = last_r;
        lfsr_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_seed_load) begin
                    lfsr_load_s = 1'b1;
                    seq_s       = SEQ_INIT;
                end else if (i_start) begin
                    state_s   = ST_HEADER;
                    len_s     = src_len_s;
                    mode_s    = src_mode_s;
                    pattern_s = src_pat_s;
                    pos_s     = '0;
                    data_s    = bld_data_s;
                    keep_s    = bld_keep_s;
                    last_s    = bld_last_s;
                    valid_s   = 1'b1;
                end else begin
                    valid_s   = 1'b0;
                end
            end
            ST_HEADER, ST_PAYLOAD: begin
                if (accept_s && last_r) begin
                    state_s = ST_IDLE;
                    seq_s   = seq_r + 32'd1;
                    pos_s   = '0;
                    data_s  = '0;
                    keep_s  = '0;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                end else if (accept_s) begin
                    state_s = (pos_next_s >= HDR_LEN) ? ST_PAYLOAD : ST_HEADER;
                    pos_s   = pos_next_s;
                    data_s  = bld_data_s;
                    keep_s  = bld_keep_s;
                    last_s  = bld_last_s;
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pos_s   = '0;
                data_s  = '0;
                keep_s  = '0;
                valid_s = 1'b0;
                last_s  = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, packet context and registered output stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            len_r     <= '0;
            mode_r    <= MODE_LFSR;
            pattern_r <= 8'h00;
            pos_r     <= '0;
            seq_r     <= SEQ_INIT;
            data_r    <= '0;
            keep_r    <= '0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            len_r     <= len_s;
            mode_r    <= mode_s;
            pattern_r <= pattern_s;
            pos_r     <= pos_s;
            seq_r     <= seq_s;
            data_r    <= data_s;
            keep_r    <= keep_s;
            valid_r   <= valid_s;
            last_r    <= last_s;
            busy_r    <= busy_s;
        end
    end

    assign o_data  = data_r;
    assign o_keep  = keep_r;
    assign o_valid = valid_r;
    assign o_last  = last_r;
    assign o_busy  = busy_r;
    assign o_seq   = seq_r;

endmodule

// File: tb/tb_payload_gen.sv
// Directed bench for payload_gen: four instances (1/2/4 lanes, and one with an
// all-ones initial sequence number) share stimulus; each scenario checks one of them.
module tb_payload_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic [1:0]  mode;
    logic [7:0]  pattern;
    logic        seed_load;
    logic [31:0] seed_data;
    logic        ready;

    logic [7:0]  d1;  logic       k1; logic v1, l1, b1; logic [31:0] s1;
    logic [15:0] d2;  logic [1:0] k2; logic v2, l2, b2; logic [31:0] s2;
    logic [31:0] d4;  logic [3:0] k4; logic v4, l4, b4; logic [31:0] s4;
    logic [31:0] dw;  logic [3:0] kw; logic vw, lw, bw; logic [31:0] sw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    payload_gen #(.DATA_BYTES(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_mode(mode),
        .i_pattern(pattern), .i_seed_load(seed_load), .i_seed_data(seed_data),
        .o_data(d1), .o_keep(k1), .o_valid(v1), .i_ready(ready), .o_last(l1),
        .o_busy(b1), .o_seq(s1));

    payload_gen #(.DATA_BYTES(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_mode(mode),
        .i_pattern(pattern), .i_seed_load(seed_load), .i_seed_data(seed_data),
        .o_data(d2), .o_keep(k2), .o_valid(v2), .i_ready(ready), .o_last(l2),
        .o_busy(b2), .o_seq(s2));

    payload_gen #(.DATA_BYTES(4)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_mode(mode),
        .i_pattern(pattern), .i_seed_load(seed_load), .i_seed_data(seed_data),
        .o_data(d4), .o_keep(k4), .o_valid(v4), .i_ready(ready), .o_last(l4),
        .o_busy(b4), .o_seq(s4));

    payload_gen #(.DATA_BYTES(4), .SEQ_INIT(32'hFFFF_FFFF)) uw (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_mode(mode),
        .i_pattern(pattern), .i_seed_load(seed_load), .i_seed_data(seed_data),
        .o_data(dw), .o_keep(kw), .o_valid(vw), .i_ready(ready), .o_last(lw),
        .o_busy(bw), .o_seq(sw));

    function automatic logic [31:0] model_lfsr(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0] == 1'b1) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; ready = 1'b1;
        len = 16'd0; mode = 2'd0; pattern = 8'h00; seed_data = 32'h0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", v1); end
        checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b1); end
        checks++; if (l1 !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", l1); end
        checks++; if (d4 !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", d4); end
        checks++; if (k4 !== 4'h0) begin errors++; $display("FAIL reset_keep got %h want 0", k4); end
        checks++; if (s1 !== 32'h0123_4567) begin errors++; $display("FAIL reset_seq got %h want 01234567", s1); end
        checks++; if (sw !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_seq_w got %h want ffffffff", sw); end
    endtask

    task automatic test_incr_db1();
        logic [7:0] exp_b [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'h01, 8'h02, 8'h03};
        do_reset();
        len = 16'd8; mode = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL incr_valid[%0d] got %b want 1", i, v1); end
            checks++; if (d1 !== exp_b[i]) begin errors++; $display("FAIL incr_data[%0d] got %h want %h", i, d1, exp_b[i]); end
            checks++; if (l1 !== (i == 7)) begin errors++; $display("FAIL incr_last[%0d] got %b want %b", i, l1, (i == 7)); end
            step();
        end
        checks++; if (v1 !== 1'b0 || b1 !== 1'b0) begin errors++; $display("FAIL incr_end valid/busy got %b/%b want 0/0", v1, b1); end
        checks++; if (s1 !== 32'h0123_4568) begin errors++; $display("FAIL incr_seq got %h want 01234568", s1); end
    endtask

    task automatic test_fixed_db4();
        logic [31:0] exp_d [3] = '{32'h0123_4567, 32'hA5A5_A5A5, 32'hA5A5_0000};
        logic [3:0]  exp_k [3] = '{4'hF, 4'hF, 4'hC};
        do_reset();
        len = 16'd10; mode = 2'd2; pattern = 8'hA5; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (d4 !== exp_d[i]) begin errors++; $display("FAIL fixed_data[%0d] got %h want %h", i, d4, exp_d[i]); end
            checks++; if (k4 !== exp_k[i]) begin errors++; $display("FAIL fixed_keep[%0d] got %h want %h", i, k4, exp_k[i]); end
            checks++; if (l4 !== (i == 2)) begin errors++; $display("FAIL fixed_last[%0d] got %b want %b", i, l4, (i == 2)); end
            step();
        end
        checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL fixed_end_valid got %b want 0", v4); end
        checks++; if (s4 !== 32'h0123_4568) begin errors++; $display("FAIL fixed_seq got %h want 01234568", s4); end
    endtask

    task automatic test_lfsr_stall_db2();
        logic [7:0]  eb [64];
        logic [31:0] m;
        logic [31:0] sq;
        logic [15:0] exp_d, prev_d;
        logic [1:0]  exp_k;
        logic        exp_l, acc, prev_stall, done;
        int          plen, idx;
        do_reset();
        m = 32'hFFFF_FFFF;
        for (int pk = 0; pk < 2; pk++) begin
            plen = (pk == 0) ? 23 : 8;
            sq   = (pk == 0) ? 32'h0123_4567 : 32'h0123_4568;
            for (int b = 0; b < 4; b++) eb[b] = sq[31-8*b -: 8];
            for (int p = 0; p < plen - 4; p++) begin
                eb[4+p] = m[31-8*(p%4) -: 8];
                if ((p % 4) == 3 || p == plen - 5) m = model_lfsr(m);
            end
            len = 16'(plen); mode = 2'd0; ready = 1'b0; start = 1'b1;
            step();
            start = 1'b0;
            idx = 0; done = 1'b0; prev_stall = 1'b0; prev_d = 16'h0;
            for (int cyc = 0; cyc < 200 && !done; cyc++) begin
                exp_d = {eb[2*idx], (2*idx+1 < plen) ? eb[2*idx+1] : 8'h00};
                exp_k = {1'b1, (2*idx+1 < plen)};
                exp_l = (2*idx+2 >= plen);
                checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL lfsr_valid pk%0d beat%0d got %b want 1", pk, idx, v2); end
                checks++; if (d2 !== exp_d) begin errors++; $display("FAIL lfsr_data pk%0d beat%0d got %h want %h", pk, idx, d2, exp_d); end
                checks++; if (k2 !== exp_k) begin errors++; $display("FAIL lfsr_keep pk%0d beat%0d got %b want %b", pk, idx, k2, exp_k); end
                checks++; if (l2 !== exp_l) begin errors++; $display("FAIL lfsr_last pk%0d beat%0d got %b want %b", pk, idx, l2, exp_l); end
                if (prev_stall) begin
                    checks++; if (d2 !== prev_d) begin errors++; $display("FAIL lfsr_hold pk%0d beat%0d got %h want %h", pk, idx, d2, prev_d); end
                end
                prev_d = d2;
                acc = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                ready = acc;
                step();
                if (acc) begin
                    idx++;
                    prev_stall = 1'b0;
                    if (exp_l) done = 1'b1;
                end else begin
                    prev_stall = 1'b1;
                end
            end
            checks++; if (!done) begin errors++; $display("FAIL lfsr_timeout pk%0d got beat %0d want completed packet", pk, idx); end
            checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL lfsr_end_valid pk%0d got %b want 0", pk, v2); end
        end
        ready = 1'b1;
    endtask

    task automatic test_seed_and_short();
        do_reset();
        len = 16'd0; mode = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (d4 !== 32'h0123_4567 || k4 !== 4'hF) begin errors++; $display("FAIL short_beat got %h/%h want 01234567/f", d4, k4); end
        checks++; if (l4 !== 1'b1 || v4 !== 1'b1) begin errors++; $display("FAIL short_last last/valid got %b/%b want 1/1", l4, v4); end
        checks++; if (dw !== 32'hFFFF_FFFF || lw !== 1'b1) begin errors++; $display("FAIL wrap_beat got %h/%b want ffffffff/1", dw, lw); end
        step();
        checks++; if (v4 !== 1'b0 || s4 !== 32'h0123_4568) begin errors++; $display("FAIL short_end valid/seq got %b/%h want 0/01234568", v4, s4); end
        checks++; if (sw !== 32'h0 || bw !== 1'b0) begin errors++; $display("FAIL wrap_seq seq/busy got %h/%b want 0/0", sw, bw); end
        seed_load = 1'b1; seed_data = 32'hDEAD_BEEF; start = 1'b1; len = 16'd8; mode = 2'd0;
        step();
        seed_load = 1'b0; start = 1'b0;
        checks++; if (v4 !== 1'b0 || b4 !== 1'b0) begin errors++; $display("FAIL seed_nostart valid/busy got %b/%b want 0/0", v4, b4); end
        checks++; if (s4 !== 32'h0123_4567) begin errors++; $display("FAIL seed_seq got %h want 01234567", s4); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (d4 !== 32'h0123_4567 || l4 !== 1'b0) begin errors++; $display("FAIL seed_hdr got %h/%b want 01234567/0", d4, l4); end
        step();
        checks++; if (d4 !== 32'hDEAD_BEEF || l4 !== 1'b1) begin errors++; $display("FAIL seed_payload got %h/%b want deadbeef/1", d4, l4); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [5] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
        do_reset();
        len = 16'd4; mode = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        len = 16'd20; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        checks++; if (d1 !== 8'h02 || s1 !== 32'h0123_4568) begin errors++; $display("FAIL mid_pre data/seq got %h/%h want 02/01234568", d1, s1); end
        rst_n = 1'b0;
        #1;
        checks++; if (v1 !== 1'b0 || b1 !== 1'b0 || l1 !== 1'b0) begin errors++; $display("FAIL mid_rst v/b/l got %b/%b/%b want 0/0/0", v1, b1, l1); end
        checks++; if (s1 !== 32'h0123_4567 || d1 !== 8'h00) begin errors++; $display("FAIL mid_rst seq/data got %h/%h want 01234567/00", s1, d1); end
        step();
        rst_n = 1'b1;
        step();
        len = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (d1 !== exp_b[i] || l1 !== (i == 4)) begin errors++; $display("FAIL mid_restart[%0d] got %h/%b want %h/%b", i, d1, l1, exp_b[i], (i == 4)); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        len = 16'd4; mode = 2'd1; start = 1'b1;
        step();
        repeat (3) step();
        checks++; if (d1 !== 8'h67 || l1 !== 1'b1) begin errors++; $display("FAIL b2b_last got %h/%b want 67/1", d1, l1); end
        step();
        checks++; if (v1 !== 1'b0 || s1 !== 32'h0123_4568) begin errors++; $display("FAIL b2b_bubble valid/seq got %b/%h want 0/01234568", v1, s1); end
        step();
        start = 1'b0;
        checks++; if (v1 !== 1'b1 || b1 !== 1'b1 || d1 !== 8'h01) begin errors++; $display("FAIL b2b_restart v/b/d got %b/%b/%h want 1/1/01", v1, b1, d1); end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_incr_db1();
        test_fixed_db4();
        test_lfsr_stall_db2();
        test_seed_and_short();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
